// File: rtl/pipeline_pkg.sv
// Shared types for the ID/EX control stage: I/O handshake state, EX control bundle, widths.
package pipeline_pkg;
    localparam int ALU_CTRL_W   = 4;
    localparam int RESULT_SRC_W = 3;

    typedef enum logic [1:0] {IDLE, OUT_WAIT, IN_WAIT} io_state_t;

    typedef struct packed {
        logic                    reg_write;
        logic                    mem_write;
        logic [RESULT_SRC_W-1:0] result_src;
        logic [ALU_CTRL_W-1:0]   alu_control;
        logic                    alu_src;
        logic                    branch;
        logic                    jump;
        logic                    alu_op_and;
        logic                    funct3_0;
    } ex_ctrl_t;

    // out wins when decode flags both directions
    function automatic io_state_t entry_state(input logic out_issued, input logic in_issued);
        if (out_issued)     return OUT_WAIT;
        else if (in_issued) return IN_WAIT;
        else                return IDLE;
    endfunction
endpackage

// File: rtl/pipeline_if.sv
// Decode->EX and EX->MEM control bundles. Modport names describe the producing stage's side,
// so the consuming/driving block sees the directions from its own viewpoint.
interface control_decode_io;
    logic                                 reg_write;
    logic                                 mem_write;
    logic [pipeline_pkg::RESULT_SRC_W-1:0] result_src;
    logic [pipeline_pkg::ALU_CTRL_W-1:0]   alu_control;
    logic                                 alu_src;
    logic                                 branch;
    logic                                 jump;
    logic                                 alu_op_and;
    logic                                 funct3_0;
    logic                                 out_issued;
    logic                                 in_issued;
    modport out (input reg_write, mem_write, result_src, alu_control, alu_src,
                       branch, jump, alu_op_and, funct3_0, out_issued, in_issued);
    modport src (output reg_write, mem_write, result_src, alu_control, alu_src,
                        branch, jump, alu_op_and, funct3_0, out_issued, in_issued);
endinterface

interface control_exec_io;
    logic                                 reg_write;
    logic                                 mem_write;
    logic [pipeline_pkg::RESULT_SRC_W-1:0] result_src;
    modport in   (output reg_write, mem_write, result_src);
    modport sink (input  reg_write, mem_write, result_src);
endinterface

// File: rtl/io_handshake_fsm.sv
// In/out port handshake tracker for the instruction in EX: stall, valid/ready, input capture.
// Optional wait timeout under IO_TIMEOUT_EN.
module io_handshake_fsm import pipeline_pkg::*; #(
    parameter int IO_W           = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            load_i,
    input  logic            out_issued_i,
    input  logic            in_issued_i,
    input  logic            out_ready_i,
    input  logic            in_valid_i,
    input  logic [IO_W-1:0] in_data_i,
    output logic            io_stall_o,
    output logic            io_kill_o,
    output logic            out_valid_o,
    output logic            in_ready_o,
    output logic [IO_W-1:0] in_data_m_o
`ifdef IO_TIMEOUT_EN
    , output logic          io_timeout_o
`endif
);
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_limit
        $error("TIMEOUT_CYCLES must fit the 16-bit wait counter");
    end

    io_state_t       state_q, state_d;
    logic [IO_W-1:0] in_data_m_q;
    logic            out_done, in_done, stall_raw, timeout_hit;

    assign out_valid_o = (state_q == OUT_WAIT);
    assign in_ready_o  = (state_q == IN_WAIT);
    assign out_done    = out_valid_o & out_ready_i;
    assign in_done     = in_ready_o & in_valid_i;
    assign stall_raw   = (out_valid_o & ~out_ready_i) | (in_ready_o & ~in_valid_i);
    assign in_data_m_o = in_data_m_q;

`ifdef IO_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
    logic [15:0] cnt_q, cnt_d;
    logic        to_q, to_d;

    assign timeout_hit  = stall_raw & (cnt_q == TO_LIM);
    assign io_stall_o   = stall_raw & ~timeout_hit;
    assign io_kill_o    = timeout_hit;
    assign io_timeout_o = to_q;

    always_comb begin
        cnt_d = cnt_q;
        if (flush_i || load_i) cnt_d = '0;
        else if (io_stall_o)   cnt_d = cnt_q + 16'd1;
        to_d = to_q | (timeout_hit & ~flush_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign io_stall_o  = stall_raw;
    assign io_kill_o   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (flush_i)                               state_d = IDLE;
        else if (load_i)                           state_d = entry_state(out_issued_i, in_issued_i);
        else if (out_done || in_done || timeout_hit) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_data_m_q <= '0;
        end else begin
            state_q <= state_d;
            if (in_done && !flush_i) in_data_m_q <= in_data_i;
        end
    end
endmodule

// File: rtl/ex_ctrl_stage.sv
// ID/EX control register, branch/jump resolution and EX/MEM control gating.
// Build with IO_TIMEOUT_EN to add the I/O wait timeout and the io_timeout port.
module ex_ctrl_stage import pipeline_pkg::*; #(
    parameter int IO_W           = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    control_decode_io.out         dec,
    control_exec_io.in            exe,
    input  logic                  stall_e,
    input  logic                  flush_e,
    input  logic                  zero_e,
    input  logic                  alu_lsb_e,
    output logic [ALU_CTRL_W-1:0] alu_control_e,
    output logic                  alu_src_e,
    output logic                  pc_src_e,
    output logic                  io_stall,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  in_ready,
    input  logic                  in_valid,
    input  logic [IO_W-1:0]       in_data,
    output logic [IO_W-1:0]       in_data_m
`ifdef IO_TIMEOUT_EN
    , output logic                io_timeout
`endif
);
    ex_ctrl_t ex_q, ex_d;
    logic     load, io_kill, cond;

    assign load = ~io_stall & ~stall_e;

    always_comb begin
        ex_d = ex_q;
        if (flush_e) begin
            ex_d = '0;
        end else if (load) begin
            ex_d.reg_write   = dec.reg_write;
            ex_d.mem_write   = dec.mem_write;
            ex_d.result_src  = dec.result_src;
            ex_d.alu_control = dec.alu_control;
            ex_d.alu_src     = dec.alu_src;
            ex_d.branch      = dec.branch;
            ex_d.jump        = dec.jump;
            ex_d.alu_op_and  = dec.alu_op_and;
            ex_d.funct3_0    = dec.funct3_0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    io_handshake_fsm #(.IO_W(IO_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_io (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_e),
        .load_i       (load),
        .out_issued_i (dec.out_issued),
        .in_issued_i  (dec.in_issued),
        .out_ready_i  (out_ready),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .io_stall_o   (io_stall),
        .io_kill_o    (io_kill),
        .out_valid_o  (out_valid),
        .in_ready_o   (in_ready),
        .in_data_m_o  (in_data_m)
`ifdef IO_TIMEOUT_EN
        , .io_timeout_o (io_timeout)
`endif
    );

    // funct3[0] inverts the sense: beq/bne on zero, blt/bge style on the slt bit
    assign cond          = (ex_q.alu_op_and ? alu_lsb_e : zero_e) ^ ex_q.funct3_0;
    assign pc_src_e      = ex_q.jump | (ex_q.branch & cond);
    assign alu_control_e = ex_q.alu_control;
    assign alu_src_e     = ex_q.alu_src;

    assign exe.reg_write  = ex_q.reg_write & ~io_stall & ~io_kill;
    assign exe.mem_write  = ex_q.mem_write & ~io_stall & ~io_kill;
    assign exe.result_src = ex_q.result_src;
endmodule
